// File: rtl/io_port_hub_if.sv
`default_nettype none
// ============================================================================
// Module      : io_port_hub_if
// Description : Processor-side and external-side handshake bundle for
//               io_port_hub. The "slave" modport is the hub's view and the
//               "master" modport is the view of the logic around it.
//               IO_HUB_STATUS_EN adds the status_clr / in_udf / ou_ovf group.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_port_hub_if #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2
);
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    // processor side
    logic                       proc_req_in;
    logic [AIW-1:0]             addr_in;
    logic signed [NUBITS-1:0]   proc_in_data;
    logic                       proc_out_en;
    logic [AOW-1:0]             addr_out;
    logic signed [NUBITS-1:0]   proc_out_data;
    logic [NUIOIN-1:0]          req_in;
    logic [NUIOOU-1:0]          out_en;

    // external side
    logic [NUIOIN*NUBITS-1:0]   ext_in_data;
    logic [NUIOIN-1:0]          ext_in_valid;
    logic [NUIOIN-1:0]          ext_in_ready;
    logic [NUIOOU*NUBITS-1:0]   ext_out_data;
    logic [NUIOOU-1:0]          ext_out_valid;
    logic [NUIOOU-1:0]          ext_out_ready;

`ifdef IO_HUB_STATUS_EN
    logic                       status_clr;
    logic [NUIOIN-1:0]          in_udf;
    logic [NUIOOU-1:0]          ou_ovf;
`endif

    modport slave (
        input  proc_req_in, addr_in, proc_out_en, addr_out, proc_out_data,
        input  ext_in_data, ext_in_valid, ext_out_ready,
        output proc_in_data, req_in, out_en,
        output ext_in_ready, ext_out_data, ext_out_valid
`ifdef IO_HUB_STATUS_EN
        , input status_clr, output in_udf, ou_ovf
`endif
    );

    modport master (
        output proc_req_in, addr_in, proc_out_en, addr_out, proc_out_data,
        output ext_in_data, ext_in_valid, ext_out_ready,
        input  proc_in_data, req_in, out_en,
        input  ext_in_ready, ext_out_data, ext_out_valid
`ifdef IO_HUB_STATUS_EN
        , output status_clr, input in_udf, ou_ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/io_port_hub.sv
`default_nettype none
// ============================================================================
// Module      : io_port_hub
// Description : Buffered I/O front end for the proc_fx soft processor.
//               Each input channel owns a FIFO filled by a valid/ready
//               producer and popped by processor reads; each output channel
//               owns a FIFO filled by processor writes and drained by a
//               valid/ready consumer. Read data and strobes are registered
//               (one-cycle latency).
//               Optional macro IO_HUB_STATUS_EN adds sticky underflow /
//               overflow flags with a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_hub #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    io_port_hub_if.slave bus
);
    localparam int AIW     = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW     = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int c_ptr_w = $clog2(FDEPTH);
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(FDEPTH);

    // input-side channel status
    logic [NUIOIN-1:0]        w_rd_sel;
    logic [NUIOIN-1:0]        w_in_empty;
    logic [NUIOIN-1:0]        w_in_full;
    logic [NUIOIN-1:0]        w_in_pop;
    logic [NUIOIN-1:0]        w_in_udf;
    logic [NUBITS-1:0]        w_in_head [NUIOIN];
    logic [NUBITS-1:0]        w_rd_data;

    // output-side channel status
    logic [NUIOOU-1:0]        w_wr_sel;
    logic [NUIOOU-1:0]        w_out_full;
    logic [NUIOOU-1:0]        w_out_valid;
    logic [NUIOOU-1:0]        w_out_ovf;
    logic [NUIOOU*NUBITS-1:0] w_out_data;

    // registered processor-facing outputs
    logic [NUIOIN-1:0]        r_req_in;
    logic [NUIOOU-1:0]        r_out_en;
    logic [NUBITS-1:0]        r_proc_in_data;

    // ------------------------------------------------------------------------
    // Input channels: producer pushes, processor pops
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUIOIN; k++) begin : g_in_ch
        logic [NUBITS-1:0]  r_mem [FDEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_ptr_w:0]   r_cnt;
        logic               w_push;

        // Ready depends on occupancy alone, so a full FIFO refuses a push
        // even when the processor pops it in the same cycle.
        assign w_in_full[k]  = (r_cnt == c_full);
        assign w_in_empty[k] = (r_cnt == '0);
        assign w_push        = bus.ext_in_valid[k] & ~w_in_full[k];
        assign w_rd_sel[k]   = bus.proc_req_in & (bus.addr_in == AIW'(k));
        // No bypass: a read of an empty FIFO underflows even if a word
        // arrives in the same cycle.
        assign w_in_pop[k]   = w_rd_sel[k] & ~w_in_empty[k];
        assign w_in_udf[k]   = w_rd_sel[k] & w_in_empty[k];
        assign w_in_head[k]  = r_mem[r_rd_ptr];

        // storage write; contents need no reset since the count gates use
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.ext_in_data[k*NUBITS +: NUBITS];
            end
        end

        // pointers wrap naturally at the power-of-two depth
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_in_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_in_pop[k]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output channels: processor pushes, consumer pops
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NUIOOU; j++) begin : g_out_ch
        logic [NUBITS-1:0]  r_mem [FDEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_ptr_w:0]   r_cnt;
        logic               w_push;
        logic               w_pop;

        assign w_out_full[j]  = (r_cnt == c_full);
        assign w_out_valid[j] = (r_cnt != '0);
        assign w_wr_sel[j]    = bus.proc_out_en & (bus.addr_out == AOW'(j));
        // A full FIFO drops the word; a same-cycle drain does not make room.
        assign w_push         = w_wr_sel[j] & ~w_out_full[j];
        assign w_out_ovf[j]   = w_wr_sel[j] & w_out_full[j];
        assign w_pop          = w_out_valid[j] & bus.ext_out_ready[j];
        // Head is forced to zero while empty so stale storage never shows.
        assign w_out_data[j*NUBITS +: NUBITS] =
            w_out_valid[j] ? r_mem[r_rd_ptr] : '0;

        // storage write from the processor data bus
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.proc_out_data;
            end
        end

        // pointers and occupancy
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Select the head of the channel being popped; at most one bit is set.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (w_in_pop[k]) begin
                w_rd_data = w_rd_data | w_in_head[k];
            end
        end
    end

    // Registered strobes and read data; out-of-range addresses leave all zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_in       <= '0;
            r_out_en       <= '0;
            r_proc_in_data <= '0;
        end else begin
            r_req_in <= w_rd_sel;
            r_out_en <= w_wr_sel;
            if (|w_in_pop) begin
                r_proc_in_data <= w_rd_data;
            end
        end
    end

    assign bus.req_in        = r_req_in;
    assign bus.out_en        = r_out_en;
    assign bus.proc_in_data  = r_proc_in_data;
    assign bus.ext_in_ready  = ~w_in_full;
    assign bus.ext_out_valid = w_out_valid;
    assign bus.ext_out_data  = w_out_data;

`ifdef IO_HUB_STATUS_EN
    logic [NUIOIN-1:0] r_in_udf;
    logic [NUIOOU-1:0] r_ou_ovf;

    // Sticky event flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_udf <= '0;
            r_ou_ovf <= '0;
        end else begin
            r_in_udf <= w_in_udf | (bus.status_clr ? '0 : r_in_udf);
            r_ou_ovf <= w_out_ovf | (bus.status_clr ? '0 : r_ou_ovf);
        end
    end

    assign bus.in_udf = r_in_udf;
    assign bus.ou_ovf = r_ou_ovf;
`else
    // Event vectors have no consumer when status reporting is compiled out.
    logic w_unused;
    assign w_unused = ^{w_in_udf, w_out_ovf};
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_port_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_hub
// Description : Self-checking bench for io_port_hub (3 inputs, 2 outputs,
//               depth 4). A queue model per channel predicts FIFO contents;
//               expected read data is queued at request time and compared
//               when the registered result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_hub;
    localparam int NB  = 32;
    localparam int NIN = 3;
    localparam int NOU = 2;
    localparam int FD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_port_hub_if #(.NUBITS(NB), .NUIOIN(NIN), .NUIOOU(NOU)) bus ();

    io_port_hub #(
        .NUBITS(NB),
        .NUIOIN(NIN),
        .NUIOOU(NOU),
        .FDEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int             n_checks = 0;
    int             n_errors = 0;
    logic [NB-1:0]  m_in  [NIN][$];
    logic [NB-1:0]  m_out [NOU][$];
    logic [NB-1:0]  sb_rd [$];
    logic [NB-1:0]  m_last = '0;
    logic [NIN-1:0] acc_in;
    logic [NIN-1:0] m_udf = '0;
    logic [NOU-1:0] m_ovf = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: check combinational outputs, update the model, clock, then
    // check registered outputs against the model.
    task automatic step();
        logic [NIN-1:0] exp_req;
        logic [NIN-1:0] udf_now;
        logic [NOU-1:0] exp_en;
        logic [NOU-1:0] ovf_now;
        logic [NOU-1:0] acc_out;
        logic [NOU-1:0] take;
        bit             popped;
        exp_req = '0; udf_now = '0; exp_en = '0; ovf_now = '0;
        acc_out = '0; take = '0; popped = 0;
        for (int k = 0; k < NIN; k++) begin
            chk("in_ready", 64'(bus.ext_in_ready[k]), 64'(m_in[k].size() < FD));
            acc_in[k] = bus.ext_in_valid[k] && (m_in[k].size() < FD);
        end
        for (int j = 0; j < NOU; j++) begin
            chk("out_valid", 64'(bus.ext_out_valid[j]), 64'(m_out[j].size() != 0));
            chk("out_data", 64'(bus.ext_out_data[j*NB +: NB]),
                64'((m_out[j].size() != 0) ? m_out[j][0] : '0));
            take[j] = bus.ext_out_ready[j] && (m_out[j].size() != 0);
            if (bus.proc_out_en && (int'(bus.addr_out) == j)) begin
                exp_en[j] = 1'b1;
                if (m_out[j].size() < FD) acc_out[j] = 1'b1;
                else                      ovf_now[j] = 1'b1;
            end
        end
        for (int k = 0; k < NIN; k++) begin
            if (bus.proc_req_in && (int'(bus.addr_in) == k)) begin
                exp_req[k] = 1'b1;
                if (m_in[k].size() > 0) begin
                    m_last = m_in[k].pop_front();
                    sb_rd.push_back(m_last);
                    popped = 1;
                end else begin
                    udf_now[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NIN; k++)
            if (acc_in[k]) m_in[k].push_back(bus.ext_in_data[k*NB +: NB]);
        for (int j = 0; j < NOU; j++) begin
            if (take[j]) void'(m_out[j].pop_front());
            if (acc_out[j]) m_out[j].push_back(bus.proc_out_data);
        end
`ifdef IO_HUB_STATUS_EN
        m_udf = udf_now | (bus.status_clr ? '0 : m_udf);
        m_ovf = ovf_now | (bus.status_clr ? '0 : m_ovf);
`endif
        tick();
        chk("req_in", 64'(bus.req_in), 64'(exp_req));
        chk("out_en", 64'(bus.out_en), 64'(exp_en));
        if (popped) chk("rd_data", 64'(bus.proc_in_data), 64'(sb_rd.pop_front()));
        else        chk("rd_hold", 64'(bus.proc_in_data), 64'(m_last));
`ifdef IO_HUB_STATUS_EN
        chk("in_udf", 64'(bus.in_udf), 64'(m_udf));
        chk("ou_ovf", 64'(bus.ou_ovf), 64'(m_ovf));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    64'(bus.proc_in_data), 64'(0));
        chk({tag, "_req"},   64'(bus.req_in), 64'(0));
        chk({tag, "_en"},    64'(bus.out_en), 64'(0));
        chk({tag, "_irdy"},  64'(bus.ext_in_ready), 64'(3'b111));
        chk({tag, "_ovld"},  64'(bus.ext_out_valid), 64'(0));
        chk({tag, "_odata"}, 64'(bus.ext_out_data), 64'(0));
`ifdef IO_HUB_STATUS_EN
        chk({tag, "_udf"},   64'(bus.in_udf), 64'(0));
        chk({tag, "_ovf"},   64'(bus.ou_ovf), 64'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.proc_req_in   = 1'b0;
        bus.addr_in       = '0;
        bus.proc_out_en   = 1'b0;
        bus.addr_out      = '0;
        bus.proc_out_data = '0;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = '0;
        bus.ext_out_ready = '0;
`ifdef IO_HUB_STATUS_EN
        bus.status_clr    = 1'b0;
`endif
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // ch1: three words, then back-to-back reads, then one read of empty
        bus.ext_in_valid = 3'b010;
        for (int i = 1; i <= 3; i++) begin
            bus.ext_in_data[1*NB +: NB] = 32'h11 * i;
            step();
        end
        bus.ext_in_valid = '0;
        bus.proc_req_in  = 1'b1;
        bus.addr_in      = 2'd1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t1_seq", 64'(bus.proc_in_data), 64'(32'h11 * i));
            chk("t1_req", 64'(bus.req_in), 64'(3'b010));
        end
        step();
        chk("t1_udf_hold", 64'(bus.proc_in_data), 64'(32'h33));
        bus.proc_req_in = 1'b0;
        step();

        // ch0: producer holds a fifth word until a read frees space
        bus.ext_in_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            bus.ext_in_data[0 +: NB] = 32'hA0 + i;
            step();
        end
        chk("t2_full", 64'(bus.ext_in_ready[0]), 64'(0));
        bus.ext_in_data[0 +: NB] = 32'hA4;
        step();
        bus.proc_req_in = 1'b1;
        bus.addr_in     = 2'd0;
        step();
        bus.proc_req_in = 1'b0;
        chk("t2_rd", 64'(bus.proc_in_data), 64'(32'hA0));
        chk("t2_rdy_back", 64'(bus.ext_in_ready[0]), 64'(1));
        step();
        bus.ext_in_valid = '0;
        chk("t2_refull", 64'(bus.ext_in_ready[0]), 64'(0));
        bus.proc_req_in = 1'b1;
        repeat (5) step();
        bus.proc_req_in = 1'b0;
        chk("t2_drain_hold", 64'(bus.proc_in_data), 64'(32'hA4));

        // ch2: push on empty with read (no bypass), then push+pop on non-empty
        bus.ext_in_valid = 3'b100;
        bus.ext_in_data[2*NB +: NB] = 32'h77;
        bus.proc_req_in = 1'b1;
        bus.addr_in     = 2'd2;
        step();
        chk("t3_nobypass", 64'(bus.proc_in_data), 64'(32'hA4));
        bus.ext_in_data[2*NB +: NB] = 32'h88;
        step();
        chk("t3_pushpop", 64'(bus.proc_in_data), 64'(32'h77));
        bus.ext_in_valid = '0;
        step();
        chk("t3_last", 64'(bus.proc_in_data), 64'(32'h88));
        bus.proc_req_in = 1'b0;

        // out-of-range read address leaves strobes and channels alone
        bus.ext_in_valid = 3'b001;
        bus.ext_in_data[0 +: NB] = 32'h55;
        step();
        bus.ext_in_valid = '0;
        bus.proc_req_in = 1'b1;
        bus.addr_in     = 2'd3;
        step();
        chk("oor_req", 64'(bus.req_in), 64'(0));
        chk("oor_hold", 64'(bus.proc_in_data), 64'(32'h88));
        bus.addr_in = 2'd0;
        step();
        chk("oor_then", 64'(bus.proc_in_data), 64'(32'h55));
        bus.proc_req_in = 1'b0;

`ifdef IO_HUB_STATUS_EN
        bus.status_clr = 1'b1;
        step();
        bus.status_clr = 1'b0;
        chk("clr_udf", 64'(bus.in_udf), 64'(0));
`endif

        // output ch1: overflow while stalled, write while full and draining
        bus.ext_out_ready = '0;
        bus.proc_out_en   = 1'b1;
        bus.addr_out      = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            bus.proc_out_data = v;
            step();
        end
        chk("ovf_head", 64'(bus.ext_out_data[1*NB +: NB]), 64'(1));
        chk("ovf_valid", 64'(bus.ext_out_valid[1]), 64'(1));
        bus.ext_out_ready = 2'b10;
        bus.proc_out_data = 6;
        step();
        bus.proc_out_en = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk("out_seq", 64'(bus.ext_out_data[1*NB +: NB]), 64'(i));
            step();
        end
        chk("out_drained", 64'(bus.ext_out_valid[1]), 64'(0));
        bus.ext_out_ready = '0;

        // async reset with data in flight
        bus.ext_in_valid = 3'b001;
        for (int i = 0; i < 2; i++) begin
            bus.ext_in_data[0 +: NB] = 32'hC1 + i;
            step();
        end
        bus.ext_in_valid = '0;
        bus.proc_out_en  = 1'b1;
        bus.addr_out     = 1'b0;
        for (int v = 7; v <= 9; v++) begin
            bus.proc_out_data = v;
            step();
        end
        bus.proc_out_en = 1'b0;
        bus.proc_req_in = 1'b1;
        bus.addr_in     = 2'd0;
        step();
        bus.proc_req_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        for (int k = 0; k < NIN; k++) m_in[k].delete();
        for (int j = 0; j < NOU; j++) m_out[j].delete();
        sb_rd.delete();
        m_last = '0;
        m_udf  = '0;
        m_ovf  = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        chk("post_rst_ovld", 64'(bus.ext_out_valid), 64'(0));
        bus.proc_req_in = 1'b1;
        bus.addr_in     = 2'd0;
        step();
        bus.proc_req_in = 1'b0;
        chk("post_rst_rd", 64'(bus.proc_in_data), 64'(0));
`ifdef IO_HUB_STATUS_EN
        chk("post_rst_udf", 64'(bus.in_udf[0]), 64'(1));
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
